// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared types for the data-memory responder.
//   mem_in_s / mem_out_s : core <-> memory handshake bundles
//   dmem_state_e         : responder FSM states
//   dmem_lfsr_seed_gp    : reset seed of the optional stall LFSR
package dmem_responder_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

  // Source of the response data word, chosen at accept.
  typedef enum logic [1:0] {RD_ZERO, RD_WORD, RD_BYTE} dmem_rd_kind_e;

  localparam logic [7:0] dmem_lfsr_seed_gp = 8'hA5;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core <-> data-memory bus.
//   to_mem_i   : request bundle from the core (mem_in_s)
//   addr_i     : byte address, sampled with to_mem_i.valid
//   from_mem_o : response bundle to the core (mem_out_s)
//   master = core side, slave = memory side
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  mem_in_s     to_mem_i;
  logic [31:0] addr_i;
  mem_out_s    from_mem_o;

  modport master (output to_mem_i, output addr_i, input from_mem_o);
  modport slave  (input to_mem_i, input addr_i, output from_mem_o);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word array, byte write enables,
// registered read.
//   clk     : clock
//   en      : access enable (read register updates, writes allowed)
//   byte_en : per-lane write enable, lane 0 = bits [7:0]
//   addr    : word index
//   wdata   : write data, lane-aligned
//   rdata   : registered read data (old contents on a write cycle)
module dmem_array #(
  parameter int unsigned addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [3:0]              byte_en,
  input  logic [addr_width_p-1:0] addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata
);

  logic [31:0] mem [0:(1 << addr_width_p)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the core's valid/yumi data-memory handshake.
// One request outstanding; word/byte stores committed at accept; load data
// returned after latency_p cycles and held until the core's yumi.
//   clk   : clock
//   reset : synchronous, active-low
//   bus   : dmem_responder_if.slave (to_mem_i, addr_i, from_mem_o)
// Optional: `define DMEM_RANDOM_STALL_EN adds 0..3 LFSR-driven stall cycles.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned addr_width_p = 10,
  parameter int unsigned latency_p    = 2
) (
  input  logic           clk,
  input  logic           reset,
  dmem_responder_if.slave bus
);

  mem_in_s                 req;
  logic [1:0]              lane;
  logic [addr_width_p-1:0] word_idx;
  logic                    unused_addr_hi;
  logic                    accept;
  logic [3:0]              byte_en;
  logic [31:0]             wdata;
  logic [31:0]             array_rdata;
  logic [4:0]              stall_extra;
  logic [4:0]              cnt_load;

  dmem_state_e   state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  dmem_rd_kind_e rd_kind_q;
  logic [1:0]    lane_q;
  mem_out_s      resp;

  assign req            = bus.to_mem_i;
  assign lane           = bus.addr_i[1:0];
  assign word_idx       = bus.addr_i[addr_width_p+1:2];
  assign unused_addr_hi = ^bus.addr_i[31:addr_width_p+2];

  assign accept  = (state_q == IDLE) & req.valid & reset;
  assign byte_en = !req.wen          ? 4'b0000 :
                   req.byte_not_word ? (4'b0001 << lane) : 4'b1111;
  assign wdata   = req.byte_not_word ? {4{req.write_data[7:0]}} : req.write_data;

  dmem_array #(.addr_width_p(addr_width_p)) u_array (
    .clk    (clk),
    .en     (accept),
    .byte_en(byte_en),
    .addr   (word_idx),
    .wdata  (wdata),
    .rdata  (array_rdata)
  );

`ifdef DMEM_RANDOM_STALL_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= dmem_lfsr_seed_gp;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign stall_extra = {3'b000, lfsr_q[1:0]};
`else
  assign stall_extra = '0;
`endif

  assign cnt_load = 5'(latency_p - 1) + stall_extra;

  // WAIT holds for cnt_load cycles; a zero load goes straight to RESP so
  // that valid always rises exactly cnt_load+1 cycles after accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = cnt_load;
          state_d = (cnt_load == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q <= 5'd1) state_d = RESP;
      end
      RESP: begin
        if (req.yumi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_kind_q <= RD_ZERO;
      lane_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rd_kind_q <= req.wen ? RD_ZERO : (req.byte_not_word ? RD_BYTE : RD_WORD);
        lane_q    <= lane;
      end
    end
  end

  // The array's read register is the captured load data; the registered
  // kind/lane select shapes it, and reset forces the response to zero.
  always_comb begin
    resp           = '0;
    resp.valid     = (state_q == RESP);
    resp.yumi      = accept;
    unique case (rd_kind_q)
      RD_WORD: resp.read_data = array_rdata;
      RD_BYTE: resp.read_data = {24'h0, array_rdata[8*lane_q +: 8]};
      default: resp.read_data = '0;
    endcase
  end

  assign bus.from_mem_o = resp;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
// (addr_width_p=10, latency_p=2).
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  dmem_responder_if bus();

  dmem_responder #(.addr_width_p(10), .latency_p(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and wait (bounded) for yumi; leaves valid low one cycle after accept.
  task automatic do_req(input logic wen, input logic bnw, input logic [31:0] addr,
                        input logic [31:0] data, output bit ok, output int acc);
    ok  = 1'b0;
    acc = -1;
    bus.addr_i                   = addr;
    bus.to_mem_i.write_data      = data;
    bus.to_mem_i.wen             = wen;
    bus.to_mem_i.byte_not_word   = bnw;
    bus.to_mem_i.valid           = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #2;
      if (bus.from_mem_o.yumi === 1'b1) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
      tick();
    end
    tick();
    bus.to_mem_i.valid = 1'b0;
  endtask

  // Cycles from accept to valid (accept cycle = 0); -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = 1;
    #2;
    while (bus.from_mem_o.valid !== 1'b1 && lat < 40) begin
      tick();
      #2;
      lat++;
    end
    if (bus.from_mem_o.valid !== 1'b1) lat = -1;
  endtask

  task automatic consume();
    bus.to_mem_i.yumi = 1'b1;
    tick();
    bus.to_mem_i.yumi = 1'b0;
  endtask

  task automatic xact(input logic wen, input logic bnw, input logic [31:0] addr,
                      input logic [31:0] data, output int lat, output logic [31:0] rd,
                      output int acc);
    bit ok;
    rd = '0;
    do_req(wen, bnw, addr, data, ok, acc);
    if (!ok) begin
      lat = -1;
      return;
    end
    wait_valid(lat);
    rd = bus.from_mem_o.read_data;
    if (lat > 0) consume();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.to_mem_i            = '0;
    bus.to_mem_i.valid      = 1'b1;
    bus.to_mem_i.wen        = 1'b1;
    bus.to_mem_i.write_data = 32'hBAD0BAD0;
    bus.addr_i              = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      #2;
      checks++;
      if (bus.from_mem_o.yumi !== 1'b0) begin
        errors++;
        $display("FAIL reset_yumi: got %b expected 0", bus.from_mem_o.yumi);
      end
    end
    checks++;
    if (bus.from_mem_o.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", bus.from_mem_o.valid);
    end
    checks++;
    if (bus.from_mem_o.read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_read_data: got %h expected 00000000", bus.from_mem_o.read_data);
    end
    bus.to_mem_i = '0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_word_round_trip();
    int lat, acc;
    logic [31:0] rd;
    xact(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, lat, rd, acc);
    checks++;
    if (lat !== 2 || rd !== 32'h0) begin
      errors++;
      $display("FAIL word_store: got lat=%0d data=%h expected lat=2 data=00000000", lat, rd);
    end
    xact(1'b0, 1'b0, 32'h40, 32'h0, lat, rd, acc);
    checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_load: got lat=%0d data=%h expected lat=2 data=deadbeef", lat, rd);
    end
  endtask

  task automatic test_byte_lanes();
    int lat, acc;
    logic [31:0] rd;
    logic [31:0] addrs [4] = '{32'h80, 32'h83, 32'h82, 32'h80};
    logic        bnws  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] exps  [4] = '{32'h11AA3344, 32'h00000011, 32'h000000AA, 32'h00000044};
    xact(1'b1, 1'b0, 32'h80, 32'h11223344, lat, rd, acc);
    xact(1'b1, 1'b1, 32'h82, 32'hFFFFFFAA, lat, rd, acc);
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, bnws[i], addrs[i], 32'h0, lat, rd, acc);
      checks++;
      if (lat !== 2 || rd !== exps[i]) begin
        errors++;
        $display("FAIL byte_lane_load[%0d]: got lat=%0d data=%h expected lat=2 data=%h",
                 i, lat, rd, exps[i]);
      end
    end
  endtask

  task automatic test_held_response();
    bit ok;
    int lat, acc;
    do_req(1'b0, 1'b0, 32'h80, 32'h0, ok, acc);
    wait_valid(lat);
    checks++;
    if (!ok || lat !== 2) begin
      errors++;
      $display("FAIL held_first_latency: got ok=%0b lat=%0d expected ok=1 lat=2", ok, lat);
    end
    // Second request presented while the response is held.
    bus.addr_i                 = 32'h40;
    bus.to_mem_i.wen           = 1'b0;
    bus.to_mem_i.byte_not_word = 1'b0;
    bus.to_mem_i.valid         = 1'b1;
    #0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.from_mem_o.valid !== 1'b1 || bus.from_mem_o.read_data !== 32'h11AA3344 ||
          bus.from_mem_o.yumi !== 1'b0) begin
        errors++;
        $display("FAIL held_cycle[%0d]: got valid=%b data=%h yumi=%b expected valid=1 data=11aa3344 yumi=0",
                 i, bus.from_mem_o.valid, bus.from_mem_o.read_data, bus.from_mem_o.yumi);
      end
      if (i < 5) begin
        tick();
        #2;
      end
    end
    bus.to_mem_i.yumi = 1'b1;
    #1;
    checks++;
    if (bus.from_mem_o.yumi !== 1'b0) begin
      errors++;
      $display("FAIL held_no_accept_in_consume_cycle: got yumi=%b expected 0", bus.from_mem_o.yumi);
    end
    tick();
    bus.to_mem_i.yumi = 1'b0;
    #2;
    checks++;
    if (bus.from_mem_o.yumi !== 1'b1) begin
      errors++;
      $display("FAIL held_accept_after_consume: got yumi=%b expected 1", bus.from_mem_o.yumi);
    end
    tick();
    bus.to_mem_i.valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat !== 2 || bus.from_mem_o.read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL held_second_load: got lat=%0d data=%h expected lat=2 data=deadbeef",
               lat, bus.from_mem_o.read_data);
    end
    if (lat > 0) consume();
  endtask

  task automatic test_wrap();
    int lat, acc;
    logic [31:0] rd;
    xact(1'b1, 1'b0, 32'h1000, 32'h5, lat, rd, acc);
    xact(1'b0, 1'b0, 32'h0, 32'h0, lat, rd, acc);
    checks++;
    if (lat !== 2 || rd !== 32'h5) begin
      errors++;
      $display("FAIL wrap_load: got lat=%0d data=%h expected lat=2 data=00000005", lat, rd);
    end
    xact(1'b0, 1'b0, 32'h3, 32'h0, lat, rd, acc);
    checks++;
    if (lat !== 2 || rd !== 32'h5) begin
      errors++;
      $display("FAIL unaligned_word_load: got lat=%0d data=%h expected lat=2 data=00000005", lat, rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int lat, acc;
    logic [31:0] rd;
    do_req(1'b1, 1'b0, 32'h10, 32'hCAFEF00D, ok, acc);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      #2;
      checks++;
      if (bus.from_mem_o.valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_wait_valid[%0d]: got %b expected 0", i, bus.from_mem_o.valid);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #2;
      checks++;
      if (bus.from_mem_o.valid !== 1'b0) begin
        errors++;
        $display("FAIL after_reset_valid[%0d]: got %b expected 0", i, bus.from_mem_o.valid);
      end
    end
    tick();
    xact(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, acc);
    checks++;
    if (lat !== 2 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL store_survives_reset: got lat=%0d data=%h expected lat=2 data=cafef00d", lat, rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat, acc, prev;
    logic [31:0] rd;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, 1'b0, (i % 2 == 0) ? 32'h40 : 32'h80, 32'h0, lat, rd, acc);
      checks++;
      if (lat !== 2 || rd !== ((i % 2 == 0) ? 32'hDEADBEEF : 32'h11AA3344)) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got lat=%0d data=%h", i, lat, rd);
      end
      if (i > 0) begin
        checks++;
        if (acc - prev !== 3) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 3", i, acc - prev);
        end
      end
      prev = acc;
    end
  endtask

`ifdef DMEM_RANDOM_STALL_EN
  task automatic test_random_stall();
    int lat, acc;
    logic [31:0] rd;
    int lats [2][16];
    for (int p = 0; p < 2; p++) begin
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) begin
        xact(1'b0, 1'b0, 32'h40, 32'h0, lat, rd, acc);
        lats[p][i] = lat;
        checks++;
        if (lat < 2 || lat > 5 || rd !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL rand_load[%0d][%0d]: got lat=%0d data=%h expected lat 2..5 data=deadbeef",
                   p, i, lat, rd);
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (lats[1][i] !== lats[0][i]) begin
        errors++;
        $display("FAIL rand_repeat[%0d]: got %0d expected %0d", i, lats[1][i], lats[0][i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word_round_trip();
    test_byte_lanes();
    test_held_response();
    test_wrap();
    test_reset_mid_wait();
    test_back_to_back();
`ifdef DMEM_RANDOM_STALL_EN
    test_random_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
